// File: rtl/obstacle_pkg.sv
// Shared constants for the obstacle path: gamestate codes, sprite
// select codes, sprite sizes, scroller state enum and width lookup.
package obstacle_pkg;

  localparam logic [1:0] GS_UNBEGIN = 2'b00;
  localparam logic [1:0] GS_RUNNING = 2'b01;
  localparam logic [1:0] GS_DEAD    = 2'b11;

  localparam logic [3:0] SEL_BIRD  = 4'b1000;
  localparam logic [3:0] SEL_CAC1S = 4'b0100;
  localparam logic [3:0] SEL_CAC1B = 4'b0101;
  localparam logic [3:0] SEL_CAC2S = 4'b0110;
  localparam logic [3:0] SEL_CAC2B = 4'b0111;

  localparam logic [7:0] W_BIRD  = 8'd92;
  localparam logic [7:0] W_CAC1S = 8'd34;
  localparam logic [7:0] W_CAC1B = 8'd50;
  localparam logic [7:0] W_CAC2S = 8'd68;
  localparam logic [7:0] W_CAC2B = 8'd100;

  localparam logic [9:0] H_SMALL = 10'd70;
  localparam logic [9:0] H_BIG   = 10'd100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCROLL,
    ST_GAP,
    ST_FROZEN
  } scroll_state_e;

  function automatic logic [7:0] obstacle_width(
    input logic [3:0] sel
  );
    logic [7:0] w;
    case (sel)
      SEL_BIRD:  w = W_BIRD;
      SEL_CAC1S: w = W_CAC1S;
      SEL_CAC1B: w = W_CAC1B;
      SEL_CAC2S: w = W_CAC2S;
      default:   w = W_CAC2B;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/obstacle_scroller_if.sv
// Bundle between obstacle scroller, selection FSM and renderer.
// master: scroller side (consumes sel/gap, drives position/advance).
interface obstacle_scroller_if;
  logic [3:0]         obstacle_sel;
  logic [9:0]         gap_width;
  logic               next_req;
  logic signed [10:0] obs_x;
  logic [9:0]         obs_y;
  logic [7:0]         obs_w;
  logic               obs_active;
  logic [3:0]         speed;

  modport master (
    input  obstacle_sel, gap_width,
    output next_req, obs_x, obs_y,
    output obs_w, obs_active, speed
  );

  modport slave (
    output obstacle_sel, gap_width,
    input  next_req, obs_x, obs_y,
    input  obs_w, obs_active, speed
  );
endinterface

// File: rtl/obstacle_speed_ramp.sv
// Frame counter plus saturating speed register.
// Ports: clk, rst, clr_i (back to initial speed), step_i (count one frame), speed_o.
module obstacle_speed_ramp #(
  parameter int SPEED_INIT        = 4,
  parameter int SPEED_MAX         = 12,
  parameter int SPEED_STEP_FRAMES = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       step_i,
  output logic [3:0] speed_o
);

  logic [9:0] frm_q, frm_d;
  logic [3:0] spd_q, spd_d;

  always_comb begin
    frm_d = frm_q;
    spd_d = spd_q;
    if (clr_i) begin
      frm_d = '0;
      spd_d = 4'(SPEED_INIT);
    end else if (step_i) begin
      if (frm_q == 10'(SPEED_STEP_FRAMES - 1)) begin
        frm_d = '0;
        if (spd_q < 4'(SPEED_MAX))
          spd_d = spd_q + 4'd1;
      end else begin
        frm_d = frm_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frm_q <= '0;
      spd_q <= 4'(SPEED_INIT);
    end else begin
      frm_q <= frm_d;
      spd_q <= spd_d;
    end
  end

  assign speed_o = spd_q;

endmodule

// File: rtl/obstacle_scroller.sv
// Per-frame horizontal scroller for the current obstacle; pulses next_req
// when it leaves the screen and respawns after a speed-scaled gap.
// Ports: clk, rst (sync, active high), gamestate, frame_tick, obs (master).
// Optional BIRD_BOB_EN: bird sprite bobs 8px every 16 frames.
module obstacle_scroller
  import obstacle_pkg::*;
#(
  parameter int SPAWN_X           = 640,
  parameter int GROUND_Y          = 400,
  parameter int BIRD_Y            = 300,
  parameter int SPEED_INIT        = 4,
  parameter int SPEED_MAX         = 12,
  parameter int SPEED_STEP_FRAMES = 600,
  parameter int GAP_SCALE         = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          gamestate,
  input  logic                frame_tick,
  obstacle_scroller_if.master obs
);

  scroll_state_e      state_q, state_d;
  logic signed [10:0] x_q, x_d;
  logic               act_q, act_d;
  logic               req_q, req_d;
  logic [3:0]         sel_q, sel_d;
  logic [12:0]        gap_q, gap_d;
  logic [1:0]         settle_q, settle_d;

  logic               spawn, go_idle;
  logic               ramp_clr, ramp_step;
  logic [3:0]         speed;
  logic [7:0]         w;
  logic signed [11:0] x_nxt;
  logic [12:0]        gap_sum, gap_tgt;
  logic               bob_up;
  logic [9:0]         y;

  assign w       = obstacle_width(sel_q);
  assign x_nxt   = $signed({x_q[10], x_q})
                 - $signed({8'd0, speed});
  assign gap_sum = gap_q + 13'(speed);
  assign gap_tgt = 13'(obs.gap_width)
                 * 13'(GAP_SCALE);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    act_d     = act_q;
    req_d     = 1'b0;
    sel_d     = sel_q;
    gap_d     = gap_q;
    settle_d  = (settle_q == 2'd2) ? settle_q
              : settle_q + 2'd1;
    spawn     = 1'b0;
    go_idle   = 1'b0;
    ramp_clr  = 1'b0;
    ramp_step = 1'b0;
    if (gamestate == GS_DEAD) begin
      state_d  = ST_FROZEN;
      settle_d = settle_q;
    end else if (gamestate == GS_RUNNING) begin
      unique case (state_q)
        ST_IDLE, ST_FROZEN: begin
          spawn    = 1'b1;
          ramp_clr = 1'b1;
        end
        ST_SCROLL: if (frame_tick) begin
          ramp_step = 1'b1;
          x_d       = x_nxt[10:0];
          if (x_nxt + $signed({4'd0, w}) <= 12'sd0) begin
            act_d    = 1'b0;
            req_d    = 1'b1;
            gap_d    = '0;
            settle_d = '0;
            state_d  = ST_GAP;
          end
        end
        ST_GAP: if (frame_tick) begin
          ramp_step = 1'b1;
          gap_d     = gap_sum;
          // gap_width is only trusted once the FSM has
          // had two cycles to react to next_req
          if (settle_q == 2'd2 && gap_sum >= gap_tgt)
            spawn = 1'b1;
        end
      endcase
    end else begin
      go_idle = 1'b1;
    end
    if (spawn) begin
      state_d = ST_SCROLL;
      x_d     = 11'(SPAWN_X);
      act_d   = 1'b1;
      sel_d   = obs.obstacle_sel;
      gap_d   = '0;
    end
    if (go_idle) begin
      state_d  = ST_IDLE;
      x_d      = 11'(SPAWN_X);
      act_d    = 1'b0;
      gap_d    = '0;
      settle_d = '0;
      ramp_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_q      <= 11'(SPAWN_X);
      act_q    <= 1'b0;
      req_q    <= 1'b0;
      sel_q    <= SEL_CAC2B;
      gap_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      act_q    <= act_d;
      req_q    <= req_d;
      sel_q    <= sel_d;
      gap_q    <= gap_d;
      settle_q <= settle_d;
    end
  end

  obstacle_speed_ramp #(
    .SPEED_INIT       (SPEED_INIT),
    .SPEED_MAX        (SPEED_MAX),
    .SPEED_STEP_FRAMES(SPEED_STEP_FRAMES)
  ) u_ramp (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (ramp_clr),
    .step_i (ramp_step),
    .speed_o(speed)
  );

`ifdef BIRD_BOB_EN
  logic [3:0] bob_cnt_q, bob_cnt_d;
  logic       bob_up_q, bob_up_d;

  always_comb begin
    bob_cnt_d = bob_cnt_q;
    bob_up_d  = bob_up_q;
    if (spawn || go_idle) begin
      bob_cnt_d = '0;
      bob_up_d  = 1'b0;
    end else if (ramp_step && state_q == ST_SCROLL) begin
      bob_cnt_d = bob_cnt_q + 4'd1;
      if (bob_cnt_q == 4'd15)
        bob_up_d = ~bob_up_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bob_cnt_q <= '0;
      bob_up_q  <= 1'b0;
    end else begin
      bob_cnt_q <= bob_cnt_d;
      bob_up_q  <= bob_up_d;
    end
  end

  assign bob_up = bob_up_q;
`else
  assign bob_up = 1'b0;
`endif

  always_comb begin
    unique case (1'b1)
      (sel_q == SEL_BIRD):
        y = bob_up ? 10'(BIRD_Y - 8) : 10'(BIRD_Y);
      (sel_q == SEL_CAC1S) || (sel_q == SEL_CAC2S):
        y = 10'(GROUND_Y) - H_SMALL;
      default:
        y = 10'(GROUND_Y) - H_BIG;
    endcase
  end

  assign obs.next_req   = req_q;
  assign obs.obs_x      = x_q;
  assign obs.obs_y      = y;
  assign obs.obs_w      = w;
  assign obs.obs_active = act_q;
  assign obs.speed      = speed;

endmodule

// File: doc/obstacle_scroller.md
Name: obstacle_scroller

Overview:
- Horizontal motion engine for the current obstacle; sits directly downstream of the obstacle-selection FSM and also drives that FSM's advance input.
- Consumes the FSM's 4-bit sprite select and 10-bit gap width. Scrolls the obstacle right-to-left once per video frame.
- When the obstacle leaves the screen, pulses next_req to advance the FSM, then waits a gap before respawning.
- Publishes x/y/active to the renderer and the collision checker.

Parameters:
- SPAWN_X, 640, left-edge x at spawn (just off right edge)
- GROUND_Y, 400, y of cactus baseline
- BIRD_Y, 300, top y of bird sprite
- SPEED_INIT, 4, pixels per frame after start
- SPEED_MAX, 12, speed ceiling
- SPEED_STEP_FRAMES, 600, frames between +1 speed steps
- GAP_SCALE, 2, gap pixels = gap_width * GAP_SCALE

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- gamestate  in  2  00 UnBegin, 01 Running, 11 Dead; 10 treated as UnBegin
- frame_tick  in  1  one-cycle pulse per frame (vsync)
- obstacle_sel  in  4  1000 Bird, 0100 Cac1S, 0101 Cac1B, 0110 Cac2S, 0111 Cac2B
- gap_width  in  10  gap width from the selection FSM
- next_req  out  1  one-cycle pulse; drives the FSM's advance input
- obs_x  out  11  signed left-edge x
- obs_y  out  10  sprite top y
- obs_w  out  8  sprite width of latched select
- obs_active  out  1  obstacle on screen
- speed  out  4  current pixels per frame

Behaviour:
- Reset (rst=1 at posedge clk):
  - state IDLE, obs_x=SPAWN_X, obs_active=0, next_req=0
  - speed=SPEED_INIT, frame and gap counters 0
  - latched select=0111 (Cac2B)
- States: IDLE, SCROLL, GAP, FROZEN. All registers update on posedge clk only.
- IDLE:
  - Outputs hold reset values.
  - gamestate=01 → SCROLL next cycle: obs_x=SPAWN_X, obs_active=1, obstacle_sel latched.
- SCROLL, on frame_tick:
  - obs_x <= obs_x - speed.
  - If (obs_x - speed + obs_w) <= 0, same edge: obs_active<=0, next_req<=1 for exactly one cycle, gap_acc<=0, state → GAP.
- GAP, on frame_tick:
  - gap_acc += speed.
  - gap_width is sampled ≥2 cycles after next_req, so the FSM's updated value is used.
  - When gap_acc+speed >= gap_width*GAP_SCALE: obs_x<=SPAWN_X, obs_active<=1, latch obstacle_sel, state → SCROLL.
- Speed ramp:
  - Frame counter increments on frame_tick in SCROLL and GAP.
  - On reaching SPEED_STEP_FRAMES-1 the counter clears and speed <= min(speed+1, SPEED_MAX).
- Width/height lookup uses the latched select:
  - Bird 92; Cac1S 34; Cac1B 50; Cac2S 68; Cac2B 100; unknown → 100.
  - obs_y: Bird → BIRD_Y; Cac1S/Cac2S → GROUND_Y-70; others → GROUND_Y-100.
- Dead (gamestate=11) from any state → FROZEN. All outputs hold, no next_req, counters hold.
- From FROZEN:
  - gamestate=00 → IDLE, with reset values except latched select.
  - gamestate=01 → SCROLL with speed=SPEED_INIT, obs_x=SPAWN_X, counters cleared.
- gamestate=00 while in SCROLL/GAP → IDLE, same as the FROZEN→IDLE case.
- Priority: rst > gamestate transitions > frame_tick. A frame_tick in the same cycle as Dead is ignored.
- Arithmetic is 12-bit signed internally to avoid underflow. obs_x never goes below -(speed+obs_w).
- next_req is registered, never asserted two cycles in a row, and never asserted outside SCROLL→GAP.
- Latency: frame_tick to obs_x update is 1 cycle.

Optional Feature:
- Macro BIRD_BOB_EN.
- Defined: while the latched select is Bird and state is SCROLL, obs_y alternates BIRD_Y / BIRD_Y-8 every 16 frame_ticks, starting at BIRD_Y on spawn. The bob counter freezes in FROZEN.
- Undefined: Bird obs_y is constant BIRD_Y and no bob counter is synthesized.

Decomposition:
- Shared package obstacle_pkg holds:
  - gamestate localparams (UnBegin/Running/Dead)
  - obstacle select codes
  - sprite width/height constants
  - state enum for this block
  - function obstacle_width(sel)
- One sub-module, obstacle_speed_ramp: frame counter plus saturating speed register with clear input.

Test Plan:
- Reset mid-SCROLL at obs_x=300 → next cycle obs_x=640, obs_active=0, speed=4, state IDLE.
- gamestate=01, sel=0111, 200 frame_ticks → obs_x decreases by 4 per tick. next_req is a single pulse on the tick where obs_x-4+100 ≤ 0 (obs_x=-96 after tick 184); obs_active=0 from then.
- After next_req, model FSM returns gap_width=50 → respawn exactly at tick 25 of GAP (4*25 ≥ 100) with the new select latched, obs_x=640.
- Dead asserted together with frame_tick at obs_x=200 → obs_x stays 200 for 50 ticks. Returning to 01 → obs_x=640, speed=4.
- 601 continuous frame_ticks while running → speed 5 after tick 600; after 6000 ticks speed saturates at 12.
- With BIRD_BOB_EN, sel=1000 → obs_y toggles 300/292 every 16 ticks. Without it, obs_y stays 300.
